data_memory_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 (pipeline MEM stage) and port 1 (loader/DMA).

---
 rtl/data_memory_arbiter.sv | 169 ++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one data memory between the MEM stage (port 0) and a loader (port 1).
// Address faults ack one cycle after the grant; normal transfers ack WAIT_CYCLES+2 cycles after the grant; a requester stalls until its ack.
module data_memory_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned DEPTH       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_out,
  output logic [1:0]  gnt,
  output logic        busy
);

  localparam logic [31:0] LP_SPAN = 32'(4 * DEPTH);
  localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;
  logic [3:0]  r_cnt;
  logic        r_owner;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_any;
  logic        w_pick;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [31:0] w_offset;
  logic        w_fault;
  logic        w_cnt_zero;

  // On a tie the port that did not win last time goes first.
  assign w_any       = m0_req | m1_req;
  assign w_pick      = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_sel_we    = w_pick ? m1_we    : m0_we;
  assign w_sel_addr  = w_pick ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_pick ? m1_wdata : m0_wdata;
  assign w_offset    = w_sel_addr - BASE_ADDR;
  assign w_fault     = (w_sel_addr[1:0] != 2'b00) || (w_offset >= LP_SPAN);
  assign w_cnt_zero  = (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_cnt   <= 4'd0;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_last  <= w_pick;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_err   <= w_fault;
            r_cnt   <= LP_WAIT;
            r_rdata <= 32'd0;
          end
        end
        S_ACCESS: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata <= r_we ? 32'd0 : mem_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = 32'd0;
    mem_data    = 32'd0;
    m0_ack      = 1'b0;
    m0_rdata    = 32'd0;
    m0_err      = 1'b0;
    m1_ack      = 1'b0;
    m1_rdata    = 32'd0;
    m1_err      = 1'b0;
    gnt         = 2'b00;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = w_fault ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        busy        = 1'b1;
        gnt         = r_owner ? 2'b10 : 2'b01;
        mem_address = r_addr;
        mem_data    = r_wdata;
        mem_read    = ~r_we;
        // A single write strobe on the final access cycle.
        mem_write   = r_we & w_cnt_zero;
        if (w_cnt_zero) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        gnt         = r_owner ? 2'b10 : 2'b01;
        w_state_nxt = S_IDLE;
        if (r_owner) begin
          m1_ack   = 1'b1;
          m1_rdata = r_rdata;
          m1_err   = r_err;
        end else begin
          m0_ack   = 1'b1;
          m0_rdata = r_rdata;
          m0_err   = r_err;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_data, mem_out;
  logic [1:0]  gnt;
  logic        busy;

  logic        z_m0_req, z_m1_req;
  logic [31:0] z_m0_addr, z_m1_addr;
  logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err;
  logic [31:0] z_m0_rdata, z_m1_rdata;
  logic        z_mem_read, z_mem_write;
  logic [31:0] z_mem_address, z_mem_data, z_mem_out;
  logic [1:0]  z_gnt;
  logic        z_busy;

  always #5 clk = ~clk;

  data_memory_arbiter #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024), .DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data(mem_data), .mem_out(mem_out), .gnt(gnt), .busy(busy)
  );

  data_memory_arbiter #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024), .DEPTH(64)) dut0 (
    .clk(clk), .rst(rst),
    .m0_req(z_m0_req), .m0_we(1'b0), .m0_addr(z_m0_addr), .m0_wdata(32'd0),
    .m0_ack(z_m0_ack), .m0_rdata(z_m0_rdata), .m0_err(z_m0_err),
    .m1_req(z_m1_req), .m1_we(1'b0), .m1_addr(z_m1_addr), .m1_wdata(32'd0),
    .m1_ack(z_m1_ack), .m1_rdata(z_m1_rdata), .m1_err(z_m1_err),
    .mem_read(z_mem_read), .mem_write(z_mem_write), .mem_address(z_mem_address),
    .mem_data(z_mem_data), .mem_out(z_mem_out), .gnt(z_gnt), .busy(z_busy)
  );

  // Memory models: combinational read, write on the rising edge.
  logic [31:0] mem    [0:63];
  logic [31:0] z_mem  [0:63];
  logic [31:0] shadow [0:63];
  logic [31:0] moff, z_moff;
  assign moff      = mem_address - 32'd1024;
  assign z_moff    = z_mem_address - 32'd1024;
  assign mem_out   = (moff < 32'd256) ? mem[moff[7:2]] : 32'hDEAD0BAD;
  assign z_mem_out = (z_moff < 32'd256) ? z_mem[z_moff[7:2]] : 32'hDEAD0BAD;

  always @(posedge clk) begin
    if (mem_write && moff < 32'd256) mem[moff[7:2]] = mem_data;
    if (z_mem_write && z_moff < 32'd256) z_mem[z_moff[7:2]] = z_mem_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;

  int wr_cnt = 0, wr_cyc = 0, rd_cnt = 0, rd_first = 0;
  always @(negedge clk) begin
    if (mem_write) begin
      wr_cnt = wr_cnt + 1;
      wr_cyc = cyc;
    end
    if (mem_read) begin
      if (rd_cnt == 0) rd_first = cyc;
      rd_cnt = rd_cnt + 1;
    end
  end

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  // Scoreboard: every ack is matched against the oldest expected transfer.
  always @(negedge clk) begin
    exp_t e;
    logic        gp;
    logic [31:0] gr;
    logic        ge;
    if (m0_ack || m1_ack) begin
      checks = checks + 1;
      if (m0_ack && m1_ack) begin
        failures = failures + 1;
        $display("FAIL sb_dual_ack: both acks high at cycle %0d", cyc);
      end else if (sb_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL sb_unexpected_ack: m0_ack=%0b m1_ack=%0b at cycle %0d, none expected", m0_ack, m1_ack, cyc);
      end else begin
        e  = sb_q.pop_front();
        gp = m1_ack;
        gr = gp ? m1_rdata : m0_rdata;
        ge = gp ? m1_err : m0_err;
        if (gp !== e.port || gr !== e.rdata || ge !== e.err) begin
          failures = failures + 1;
          $display("FAIL sb_xfer: got port=%0d rdata=%h err=%0b, expected port=%0d rdata=%h err=%0b",
                   gp, gr, ge, e.port, e.rdata, e.err);
        end
        checks = checks + 1;
        if ((gp ? {m0_rdata, m0_err} : {m1_rdata, m1_err}) !== 33'd0) begin
          failures = failures + 1;
          $display("FAIL sb_idle_port: non-granted port outputs nonzero at cycle %0d", cyc);
        end
      end
    end
  end

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hA5, b, ~b, 8'h3C};
  endfunction

  task automatic wait_ack(input bit port, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (port ? m1_ack : m0_ack) seen = 1'b1;
    end
  endtask

  task automatic do_xfer(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input string name);
    exp_t        e;
    logic [31:0] off;
    bit          fault, seen;
    int          t, exp_lat;
    off     = addr - 32'd1024;
    fault   = (addr[1:0] != 2'b00) || (off >= 32'd256);
    e.port  = port;
    e.err   = fault;
    e.rdata = (fault || we) ? 32'd0 : shadow[off[7:2]];
    exp_lat = fault ? 1 : W + 2;
    sb_q.push_back(e);
    if (!fault && we) shadow[off[7:2]] = wdata;
    @(posedge clk); #1;
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
    t = cyc; wr_cnt = 0; rd_cnt = 0;
    wait_ack(port, seen);
    #1;
    checks = checks + 1;
    if (!seen) begin
      failures = failures + 1;
      $display("FAIL %s_timeout: no ack within 40 cycles", name);
    end else begin
      if (cyc - t != exp_lat) begin
        failures = failures + 1;
        $display("FAIL %s_latency: ack after %0d cycles, expected %0d", name, cyc - t, exp_lat);
      end
      checks = checks + 1;
      if (fault) begin
        if (wr_cnt != 0 || rd_cnt != 0) begin
          failures = failures + 1;
          $display("FAIL %s_strobe: wr=%0d rd=%0d on fault, expected 0/0", name, wr_cnt, rd_cnt);
        end
      end else if (we) begin
        if (wr_cnt != 1 || wr_cyc != t + W + 1) begin
          failures = failures + 1;
          $display("FAIL %s_strobe: wr=%0d at +%0d, expected 1 at +%0d", name, wr_cnt, wr_cyc - t, W + 1);
        end
      end else begin
        if (rd_cnt != W + 1 || rd_first != t + 1) begin
          failures = failures + 1;
          $display("FAIL %s_strobe: rd=%0d from +%0d, expected %0d from +1", name, rd_cnt, rd_first - t, W + 1);
        end
      end
    end
    @(posedge clk); #1;
    if (port) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks = checks + 3;
    if ({gnt, busy, m0_ack, m1_ack, m0_err, m1_err, z_busy} !== 8'd0) begin
      failures = failures + 1;
      $display("FAIL reset_ctrl: gnt=%b busy=%b acks=%b%b errs=%b%b, expected all 0", gnt, busy, m0_ack, m1_ack, m0_err, m1_err);
    end
    if ({mem_read, mem_write, mem_address, mem_data} !== 66'd0) begin
      failures = failures + 1;
      $display("FAIL reset_mem: rd=%b wr=%b addr=%h data=%h, expected 0", mem_read, mem_write, mem_address, mem_data);
    end
    if ({m0_rdata, m1_rdata} !== 64'd0) begin
      failures = failures + 1;
      $display("FAIL reset_rdata: %h %h, expected 0", m0_rdata, m1_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    do_xfer(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, "wr1024");
    do_xfer(1'b0, 1'b0, 32'd1024, 32'd0, "rd1024");
    do_xfer(1'b1, 1'b0, 32'd1276, 32'd0, "rd_last");
  endtask

  task automatic test_fault;
    do_xfer(1'b1, 1'b0, 32'd1026, 32'd0, "misalign");
    do_xfer(1'b1, 1'b0, 32'd1280, 32'd0, "range");
    do_xfer(1'b1, 1'b1, 32'd1020, 32'h12345678, "below_base_wr");
    do_xfer(1'b0, 1'b0, 32'd1024, 32'd0, "rd_after_fault");
  endtask

  task automatic test_arb;
    exp_t e;
    bit   seen;
    int   t;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    e.port = 1'b0; e.rdata = shadow[0]; e.err = 1'b0; sb_q.push_back(e);
    e.port = 1'b1; e.rdata = shadow[1]; e.err = 1'b0; sb_q.push_back(e);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1024;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd1028;
    t = cyc;
    @(negedge clk); @(negedge clk);
    checks = checks + 1;
    if (gnt !== 2'b01) begin
      failures = failures + 1;
      $display("FAIL arb_first_gnt: gnt=%b, expected 01", gnt);
    end
    wait_ack(1'b0, seen);
    checks = checks + 1;
    if (!seen || cyc != t + W + 2) begin
      failures = failures + 1;
      $display("FAIL arb_m0_ack: seen=%0b at +%0d, expected +%0d", seen, cyc - t, W + 2);
    end
    @(posedge clk); #1 m0_req = 1'b0;
    @(negedge clk); @(negedge clk);
    checks = checks + 1;
    if (gnt !== 2'b10) begin
      failures = failures + 1;
      $display("FAIL arb_second_gnt: gnt=%b, expected 10", gnt);
    end
    wait_ack(1'b1, seen);
    checks = checks + 1;
    if (!seen || cyc != t + 2 * W + 5) begin
      failures = failures + 1;
      $display("FAIL arb_m1_ack: seen=%0b at +%0d, expected +%0d", seen, cyc - t, 2 * W + 5);
    end
    @(posedge clk); #1 m1_req = 1'b0;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   n_ack, first_cyc, last_cyc;
    for (int i = 0; i < 4; i++) begin
      e.port = 1'(i % 2); e.rdata = (i % 2 == 0) ? shadow[2] : shadow[3]; e.err = 1'b0;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1032;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd1036;
    n_ack = 0; first_cyc = 0; last_cyc = 0;
    for (int n = 0; n < 60 && n_ack < 4; n++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        if (n_ack == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_ack = n_ack + 1;
      end
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    checks = checks + 1;
    if (n_ack != 4 || last_cyc - first_cyc != 3 * (W + 3)) begin
      failures = failures + 1;
      $display("FAIL b2b_throughput: acks=%0d span=%0d, expected 4 and %0d", n_ack, last_cyc - first_cyc, 3 * (W + 3));
    end
  endtask

  task automatic test_reset_abort;
    int n_ack;
    do_xfer(1'b0, 1'b1, 32'd1028, 32'h11111111, "wr1028_old");
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd1028; m0_wdata = 32'h22222222;
    wr_cnt = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; m0_req = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (busy !== 1'b0 || gnt !== 2'b00) begin
      failures = failures + 1;
      $display("FAIL abort_idle: busy=%b gnt=%b, expected 0/00", busy, gnt);
    end
    n_ack = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) n_ack = n_ack + 1;
    end
    checks = checks + 1;
    if (wr_cnt != 0 || n_ack != 0) begin
      failures = failures + 1;
      $display("FAIL abort_quiet: writes=%0d acks=%0d, expected 0/0", wr_cnt, n_ack);
    end
    do_xfer(1'b1, 1'b0, 32'd1028, 32'd0, "rd1028_after_abort");
  endtask

  task automatic test_wait0;
    logic [31:0] addrs [0:1];
    int          lats  [0:1];
    logic [31:0] exps  [0:1];
    logic        errs  [0:1];
    bit          seen;
    int          t;
    addrs[0] = 32'd1276; lats[0] = 2; exps[0] = pat(63); errs[0] = 1'b0;
    addrs[1] = 32'd1020; lats[1] = 1; exps[1] = 32'd0;   errs[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      z_m0_req = 1'b1; z_m0_addr = addrs[k];
      t = cyc; seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        if (z_m0_ack) seen = 1'b1;
      end
      checks = checks + 1;
      if (!seen || cyc - t != lats[k] || z_m0_rdata !== exps[k] || z_m0_err !== errs[k] || z_m1_ack !== 1'b0) begin
        failures = failures + 1;
        $display("FAIL w0_xfer%0d: seen=%0b lat=%0d rdata=%h err=%b, expected lat=%0d rdata=%h err=%b",
                 k, seen, cyc - t, z_m0_rdata, z_m0_err, lats[k], exps[k], errs[k]);
      end
      @(posedge clk); #1 z_m0_req = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = pat(i); z_mem[i] = pat(i); shadow[i] = pat(i);
    end
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
    z_m0_req = 1'b0; z_m0_addr = 32'd0; z_m1_req = 1'b0; z_m1_addr = 32'd0;
    test_reset();
    test_write_read();
    test_fault();
    test_arb();
    test_back_to_back();
    test_reset_abort();
    test_wait0();
    repeat (3) @(posedge clk);
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL sb_leftover: %0d expected transfers never acked", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
